// File: rtl/led_level_meter.sv
// LED bar-graph level meter: DC removal, rectified window peak, peak-hold with slow decay, thermometer bar.
// Define LED_METER_AUTO_ZERO_EN to learn the DC offset (CAL state, recal input); otherwise offset is fixed at 512.
module led_level_meter #(
    parameter int  NUM_LEDS      = 16,
    parameter int  WINDOW_LOG2   = 5,
    parameter int  DECAY_WINDOWS = 4,
    parameter int  CAL_LOG2      = 4,
    localparam int LW            = $clog2(NUM_LEDS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          sample,
    input  logic                sample_valid,
    input  logic                recal,
    output logic [LW-1:0]       level,
    output logic [NUM_LEDS-1:0] bar,
    output logic                level_valid,
    output logic                calibrating,
    output logic [9:0]          offset
);

    localparam int DW = (DECAY_WINDOWS > 1) ? $clog2(DECAY_WINDOWS) : 1;
    localparam int PW = 9 + LW;
    localparam logic [WINDOW_LOG2-1:0] WIN_LAST   = '1;
    localparam logic [DW-1:0]          DECAY_LAST = DW'(DECAY_WINDOWS - 1);

    logic                   run;
    logic                   flush;

    logic [9:0]             smp_r;
    logic                   smp_v;
    logic [8:0]             mag_r;
    logic                   mag_v;
    logic [8:0]             win_peak;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [8:0]             fin_r;
    logic                   fin_v;
    logic [DW-1:0]          dcnt;

    logic [9:0]             abs_diff;
    logic [8:0]             mag_sat;
    logic [8:0]             peak_next;
    logic [LW-1:0]          raw;
    logic [LW-1:0]          level_next;
    logic [DW-1:0]          dcnt_next;

`ifdef LED_METER_AUTO_ZERO_EN
    localparam int SW = 10 + CAL_LOG2;

    typedef enum logic {CAL, RUN} state_t;

    state_t              state;
    logic [SW-1:0]       sum;
    logic [SW-1:0]       sum_next;
    logic [CAL_LOG2-1:0] cal_cnt;

    assign run         = (state == RUN);
    assign flush       = recal;
    assign calibrating = (state == CAL);
    assign sum_next    = sum + SW'(sample);
`else
    logic unused_recal;

    assign run          = 1'b1;
    assign flush        = 1'b0;
    assign calibrating  = 1'b0;
    assign offset       = 10'd512;
    assign unused_recal = recal;
`endif

    function automatic logic [NUM_LEDS-1:0] thermo(input logic [LW-1:0] n);
        logic [NUM_LEDS-1:0] t;
        for (int i = 0; i < NUM_LEDS; i++) begin
            t[i] = (i < int'(n));
        end
        return t;
    endfunction

    // Stage A: rectify against the offset and clip to 9 bits.
    always_comb begin
        abs_diff = (smp_r >= offset) ? (smp_r - offset) : (offset - smp_r);
        mag_sat  = abs_diff[9] ? 9'd511 : abs_diff[8:0];
    end

    assign peak_next = (mag_r > win_peak) ? mag_r : win_peak;

    // Stage C: quantize the window peak and run the peak-hold/decay rule.
    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        raw        = LW'((PW'(fin_r) * PW'(NUM_LEDS + 1)) >> 9);
        level_next = level;
        dcnt_next  = dcnt;
        if (raw >= level) begin
            level_next = raw;
            dcnt_next  = '0;
        end else if (dcnt == DECAY_LAST) begin
            level_next = level - LW'(1);
            dcnt_next  = '0;
        end else begin
            dcnt_next  = dcnt + DW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; data registers are reset too so
    // nothing downstream ever sees X out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_r       <= '0;
            smp_v       <= 1'b0;
            mag_r       <= '0;
            mag_v       <= 1'b0;
            win_peak    <= '0;
            win_cnt     <= '0;
            fin_r       <= '0;
            fin_v       <= 1'b0;
            dcnt        <= '0;
            level       <= '0;
            bar         <= '0;
            level_valid <= 1'b0;
`ifdef LED_METER_AUTO_ZERO_EN
            state       <= CAL;
            sum         <= '0;
            cal_cnt     <= '0;
            offset      <= 10'd512;
`endif
        end else if (flush) begin
            smp_v       <= 1'b0;
            mag_v       <= 1'b0;
            fin_v       <= 1'b0;
            win_peak    <= '0;
            win_cnt     <= '0;
            dcnt        <= '0;
            level       <= '0;
            bar         <= '0;
            level_valid <= 1'b0;
`ifdef LED_METER_AUTO_ZERO_EN
            state       <= CAL;
            sum         <= '0;
            cal_cnt     <= '0;
`endif
        end else begin
            // The sample is registered on its accepting edge so the window result lands on the third edge after it.
            smp_v <= sample_valid && run;
            if (sample_valid) begin
                smp_r <= sample;
            end

            mag_v <= smp_v;
            if (smp_v) begin
                mag_r <= mag_sat;
            end

            fin_v <= mag_v && (win_cnt == WIN_LAST);
            if (mag_v) begin
                if (win_cnt == WIN_LAST) begin
                    fin_r    <= peak_next;
                    win_peak <= '0;
                    win_cnt  <= '0;
                end else begin
                    win_peak <= peak_next;
                    win_cnt  <= win_cnt + WINDOW_LOG2'(1);
                end
            end

            level_valid <= fin_v;
            if (fin_v) begin
                level <= level_next;
                bar   <= thermo(level_next);
                dcnt  <= dcnt_next;
            end

`ifdef LED_METER_AUTO_ZERO_EN
            if (state == CAL && sample_valid) begin
                if (cal_cnt == '1) begin
                    offset  <= sum_next[SW-1:CAL_LOG2];
                    sum     <= '0;
                    cal_cnt <= '0;
                    state   <= RUN;
                end else begin
                    sum     <= sum_next;
                    cal_cnt <= cal_cnt + CAL_LOG2'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_led_level_meter.sv
// Bench for led_level_meter: window vector table and random windows, results scoreboarded on level_valid.
module tb_led_level_meter;

    localparam int NUM_LEDS = 16;
    localparam int LW       = 5;
    localparam int WIN      = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [9:0]          sample;
    logic                sample_valid;
    logic                recal;
    logic [LW-1:0]       level;
    logic [NUM_LEDS-1:0] bar;
    logic                level_valid;
    logic                calibrating;
    logic [9:0]          offset;

    led_level_meter dut (
        .clk         (clk),
        .rst         (rst),
        .sample      (sample),
        .sample_valid(sample_valid),
        .recal       (recal),
        .level       (level),
        .bar         (bar),
        .level_valid (level_valid),
        .calibrating (calibrating),
        .offset      (offset)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_push   = 0;
    int n_pop    = 0;

    typedef struct { int level; int bar; int acc; } exp_t;
    typedef struct { int fill; int peak; int pos; int exp_level; int exp_bar; } vec_t;

    exp_t       sb[$];
    exp_t       got;
    vec_t       vecs[20];
    logic [9:0] win_buf[WIN];

    int m_level  = 0;
    int m_dcnt   = 0;
    int m_offset = 512;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // Scoreboard: every level_valid pulse must match the oldest outstanding window.
    always @(negedge clk) begin
        if (level_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_level_valid", 1, 0);
            end else begin
                got = sb.pop_front();
                n_pop++;
                check("level", int'(level), got.level);
                check("bar", int'(bar), got.bar);
                check("latency", cyc - got.acc, 3);
            end
        end
    end

    function automatic int f_mag(input int s, input int off);
        int d;
        d = (s > off) ? s - off : off - s;
        return (d > 511) ? 511 : d;
    endfunction

    function automatic int f_bar(input int lvl);
        return (1 << lvl) - 1;
    endfunction

    task automatic model_step();
        int pk;
        int raw;
        pk = 0;
        for (int k = 0; k < WIN; k++) begin
            if (f_mag(int'(win_buf[k]), m_offset) > pk) pk = f_mag(int'(win_buf[k]), m_offset);
        end
        raw = (pk * (NUM_LEDS + 1)) / 512;
        if (raw >= m_level) begin
            m_level = raw;
            m_dcnt  = 0;
        end else if (m_dcnt == 3) begin
            m_level = m_level - 1;
            m_dcnt  = 0;
        end else begin
            m_dcnt = m_dcnt + 1;
        end
    endtask

    task automatic put(input logic [9:0] s, input bit rc);
        sample       = s;
        sample_valid = 1'b1;
        recal        = rc;
        @(negedge clk);
        sample_valid = 1'b0;
        recal        = 1'b0;
    endtask

    task automatic run_window(input int tl, input int tbar, input bit use_model, input bit gaps, input int recal_at);
        exp_t e;
        model_step();
        if (use_model) begin
            e.level = m_level;
            e.bar   = f_bar(m_level);
        end else begin
            e.level = tl;
            e.bar   = tbar;
        end
        for (int k = 0; k < WIN; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            put(win_buf[k], k == recal_at);
        end
        e.acc = cyc;
        sb.push_back(e);
        n_push++;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic calibrate(input logic [9:0] v, input logic [9:0] vlast, input int exp_off);
        for (int k = 0; k < 15; k++) put(v, 1'b0);
        check("calibrating_before_last", int'(calibrating), 1);
        put(vlast, 1'b0);
        check("cal_offset", int'(offset), exp_off);
        check("calibrating_fell", int'(calibrating), 0);
        m_offset = exp_off;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{512, 256,  5,  8, 'h00FF};
        vecs[1]  = '{512, 1023, 31, 16, 'hFFFF};
        vecs[2]  = '{512, 512,  0, 16, 'hFFFF};
        vecs[3]  = '{512, 512,  0, 16, 'hFFFF};
        vecs[4]  = '{512, 1023, 0, 16, 'hFFFF};
        vecs[5]  = '{512, 512,  0, 16, 'hFFFF};
        vecs[6]  = '{512, 512,  0, 16, 'hFFFF};
        vecs[7]  = '{512, 512,  0, 16, 'hFFFF};
        vecs[8]  = '{512, 512,  0, 15, 'h7FFF};
        vecs[9]  = '{512, 512,  0, 15, 'h7FFF};
        vecs[10] = '{512, 512,  0, 15, 'h7FFF};
        vecs[11] = '{512, 512,  0, 15, 'h7FFF};
        vecs[12] = '{512, 512,  0, 14, 'h3FFF};
        vecs[13] = '{512, 543, 17, 14, 'h3FFF};
        vecs[14] = '{512, 0,    3, 16, 'hFFFF};
        vecs[15] = '{512, 768,  9, 16, 'hFFFF};
        vecs[16] = '{512, 542, 20, 16, 'hFFFF};
        vecs[17] = '{512, 481, 30, 16, 'hFFFF};
        vecs[18] = '{400, 300, 12, 15, 'h7FFF};
        vecs[19] = '{1,   1,    0, 16, 'hFFFF};

        rst          = 1'b1;
        sample       = '0;
        sample_valid = 1'b0;
        recal        = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_level", int'(level), 0);
        check("rst_bar", int'(bar), 0);
        check("rst_level_valid", int'(level_valid), 0);
        check("rst_offset", int'(offset), 512);

`ifdef LED_METER_AUTO_ZERO_EN
        check("rst_calibrating", int'(calibrating), 1);
        calibrate(10'd500, 10'd500, 500);
        for (int k = 0; k < WIN; k++) win_buf[k] = 10'd500;
        run_window(0, 0, 1'b0, 1'b0, -1);
        drain();

        // Recalibrate to 512; the odd last sample checks truncation of the average.
        recal = 1'b1;
        @(negedge clk);
        recal = 1'b0;
        check("recal_calibrating", int'(calibrating), 1);
        m_level = 0;
        m_dcnt  = 0;
        calibrate(10'd512, 10'd527, 512);
`else
        check("rst_calibrating", int'(calibrating), 0);
`endif

        foreach (vecs[i]) begin
            for (int k = 0; k < WIN; k++) begin
                win_buf[k] = 10'((k == vecs[i].pos) ? vecs[i].peak : vecs[i].fill);
            end
            run_window(vecs[i].exp_level, vecs[i].exp_bar, 1'b0, (i % 4) == 3, -1);
        end
        drain();

`ifdef LED_METER_AUTO_ZERO_EN
        // recal mid-window with a coincident sample: sample dropped, level cleared, no result.
        for (int k = 0; k < 10; k++) put(10'd512, 1'b0);
        put(10'd1023, 1'b1);
        check("recal_calibrating_mid", int'(calibrating), 1);
        check("recal_level", int'(level), 0);
        check("recal_bar", int'(bar), 0);
        check("recal_level_valid", int'(level_valid), 0);
        repeat (6) @(negedge clk);
        m_level = 0;
        m_dcnt  = 0;
        calibrate(10'd600, 10'd600, 600);
`else
        // recal is ignored: the peak sample sent alongside it must still count.
        for (int k = 0; k < WIN; k++) win_buf[k] = (k == 10) ? 10'd0 : 10'd512;
        run_window(0, 0, 1'b1, 1'b0, 10);
        check("recal_ignored_calibrating", int'(calibrating), 0);
        check("recal_ignored_offset", int'(offset), 512);
        drain();
`endif

        for (int w = 0; w < 6; w++) begin
            int a;
            int lo;
            int hi;
            a  = int'($urandom_range(0, 511));
            lo = (m_offset - a < 0) ? 0 : m_offset - a;
            hi = (m_offset + a > 1023) ? 1023 : m_offset + a;
            for (int k = 0; k < WIN; k++) win_buf[k] = 10'($urandom_range(lo, hi));
            run_window(0, 0, 1'b1, 1'b1, -1);
        end
        drain();

        // rst must win over a window result already in the pipeline.
        for (int k = 0; k < WIN; k++) put((k == WIN - 1) ? 10'd1023 : 10'(m_offset), 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_prio_level", int'(level), 0);
        check("rst_prio_bar", int'(bar), 0);
        check("rst_prio_level_valid", int'(level_valid), 0);
        repeat (4) @(negedge clk);

        check("pushes_popped", n_pop, n_push);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
